serial_addsub_ctrl: RTL

Bit-serial add/subtract sequencer built around a single reversible adder-cum-subtractor cell. It accepts two WIDTH-bit operands plus a mode bit over a valid/ready handshake and steps the cell LSB-first for WIDTH cycles, holding carry/borrow in a register between steps. It presents the result, final carry/borrow and, optionally, signed overflow over a second valid/ready handshake. It is the sequencing layer that lets the one-bit reversible cell serve as an N-bit arithmetic unit.

---
 rtl/serial_addsub_pkg.sv | 21 ++
 rtl/full_adder_cum_subtractor.sv | 30 +++
 rtl/serial_addsub_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared definitions for the bit-serial add/subtract sequencer.
//   state_e    FSM state encoding (idle / run / done)
//   MODE_ADD   mode value selecting A+B+cin
//   MODE_SUB   mode value selecting A-B-cin
//   WIDTH_MIN  smallest legal operand width
//   WIDTH_MAX  largest legal operand width
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

endpackage

// File: rtl/full_adder_cum_subtractor.sv
// full_adder_cum_subtractor: one-bit reversible adder/subtractor cell built from Feynman (CNOT)
// and Peres gates. Garbage outputs of the reversible network are not brought out.
//   a, b      operand bits (a is the minuend when subtracting)
//   c         carry-in (add) or borrow-in (sub)
//   mode      0 = add, 1 = subtract
//   sum       a ^ b ^ c in both modes
//   cout_brw  full-adder carry (add) or full-subtractor borrow (sub)
module full_adder_cum_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic mode,
  output logic sum,
  output logic cout_brw
);

  logic a_m;     // Feynman(mode, a): a conditionally inverted for subtraction
  logic p1_xor;  // Peres #1 (a_m, b, 0): propagate
  logic p1_and;  // Peres #1: generate
  logic s_raw;   // Peres #2 (p1_xor, c, p1_and): sum of a_m, b, c

  assign a_m      = a ^ mode;
  assign p1_xor   = a_m ^ b;
  assign p1_and   = a_m & b;
  assign s_raw    = p1_xor ^ c;
  assign cout_brw = (p1_xor & c) ^ p1_and;
  // Second Feynman gate undoes the mode inversion so the sum is a ^ b ^ c in both modes.
  assign sum      = s_raw ^ mode;

endmodule

// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl: bit-serial add/subtract sequencer around one reversible cell.
// Operands are accepted over a valid/ready handshake, processed LSB-first for WIDTH cycles
// with carry/borrow held in a register, and the result is offered over a second handshake.
// Optional feature macro: ADDSUB_OVERFLOW_EN adds the registered signed-overflow output.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand request          in_ready   high in idle while rst is low
//   a, b       operands                 cin        carry-in / borrow-in for bit 0
//   mode       0 = add, 1 = subtract (sampled at accept only)
//   out_valid  result available         out_ready  result consumed
//   result     sum or difference        cout_brw   final carry / borrow
//   overflow   signed overflow (ADDSUB_OVERFLOW_EN only)
module serial_addsub_ctrl
  import serial_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout_brw
`ifdef ADDSUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_addsub_ctrl: WIDTH out of legal range");
  end

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

`ifdef ADDSUB_OVERFLOW_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  logic cell_sum;
  logic cell_cout;

  full_adder_cum_subtractor u_cell (
    .a        (a_sh_q[0]),
    .b        (b_sh_q[0]),
    .c        (carry_q),
    .mode     (mode_q),
    .sum      (cell_sum),
    .cout_brw (cell_cout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
`ifdef ADDSUB_OVERFLOW_EN
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    ovf_d    = ovf_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          mode_d  = mode;
          cnt_d   = '0;
`ifdef ADDSUB_OVERFLOW_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {cell_sum, res_sh_q[WIDTH-1:1]};
        carry_d  = cell_cout;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StDone;
`ifdef ADDSUB_OVERFLOW_EN
          // On the final step the cell's sum bit is the result MSB.
          if (mode_q == MODE_ADD) begin
            ovf_d = (a_msb_q == b_msb_q) && (cell_sum != a_msb_q);
          end else begin
            ovf_d = (a_msb_q != b_msb_q) && (cell_sum != a_msb_q);
          end
`endif
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      mode_q   <= 1'b0;
      cnt_q    <= '0;
`ifdef ADDSUB_OVERFLOW_EN
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
`ifdef ADDSUB_OVERFLOW_EN
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign result    = res_sh_q;
  assign cout_brw  = carry_q;
`ifdef ADDSUB_OVERFLOW_EN
  assign overflow  = ovf_q;
`endif

endmodule
